// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: performs an NBYTES-wide addition by running a single
// 8-bit adder once per byte, least-significant byte first. The carry between
// bytes is held in a register. A start/busy/done handshake frames each
// operation.
module adder_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  a_sr, b_sr, res_sr, res_next;
  logic          carry_r;
  logic [IW-1:0] idx;
  logic [7:0]    add_sum;
  logic          add_cout;
  logic          accept;
  logic          last;

  // The one shared 8-bit adder, plus the result register's next value with
  // the new byte entering at the top (written as a shift so NBYTES=1 works).
  always_comb begin
    {add_cout, add_sum} = {1'b0, a_sr[7:0]} + {1'b0, b_sr[7:0]} + {8'd0, carry_r};
    res_next = (res_sr >> 8) | (W'(add_sum) << (W - 8));
  end

  // Handshake decode: operands are taken only from IDLE or DONE.
  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
    last   = (state == RUN) && (idx == LAST);
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == RUN);
      done  <= (state_d == DONE);
    end
  end

  // Operand capture, byte-serial datapath and the result/carry outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 8;
      b_sr    <= b_sr >> 8;
      res_sr  <= res_next;
      carry_r <= add_cout;
      idx     <= idx + 1'b1;
      if (last) begin
        sum  <= res_next;
        cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed cases plus random
// traffic, compared cycle by cycle against a timeline/arithmetic model.
module tb_adder_seq_ctrl;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start1, cin1;
  logic [7:0]   a1, b1;
  logic         busy1, done1, cout1;
  logic [7:0]   sum1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase counts edges since the accepting edge.
  bit           m_active = 1'b0;
  int           m_ph     = 0;
  logic [W:0]   m_pend   = '0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  adder_seq_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic r, input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic cv);
    logic exp_busy, exp_done;
    rst = r; start = s; a = av; b = bv; cin = cv;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_ph = 0; m_sum = '0; m_cout = 1'b0;
    end else if (s && (!m_active || m_ph == NBYTES + 1)) begin
      m_active = 1'b1;
      m_ph     = 1;
      m_pend   = {1'b0, av} + {1'b0, bv} + (W + 1)'(cv);
    end else if (m_active) begin
      m_ph++;
      if (m_ph == NBYTES + 1) {m_cout, m_sum} = m_pend;
      if (m_ph > NBYTES + 1) m_active = 1'b0;
    end
    exp_busy = m_active && (m_ph <= NBYTES);
    exp_done = m_active && (m_ph == NBYTES + 1);
    #1;
    check("busy", (W + 1)'(busy), (W + 1)'(exp_busy));
    check("done", (W + 1)'(done), (W + 1)'(exp_done));
    check("sum",  (W + 1)'(sum),  (W + 1)'(m_sum));
    check("cout", (W + 1)'(cout), (W + 1)'(m_cout));
    check("busy_done_excl", (W + 1)'(busy & done), '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rnd_w(), rnd_w(), 1'($urandom()));
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    cycle(1'b0, 1'b1, av, bv, cv);
    idle(NBYTES + 2);
  endtask

  initial begin
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Directed arithmetic cases
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    check("plan_sum_1", (W + 1)'({cout, sum}), 33'h0_2345_6789);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check("plan_ripple", (W + 1)'({cout, sum}), 33'h1_0000_0000);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    check("plan_top_carry", (W + 1)'({cout, sum}), 33'h1_0000_0000);

    // start while busy is ignored
    cycle(1'b0, 1'b1, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    idle(NBYTES + 3);
    check("plan_ignore", (W + 1)'({cout, sum}), 33'h0_0100_0100);

    // start held high: back-to-back results every NBYTES+1 cycles
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h1, 32'h2, 1'b0);
    check("b2b_first", (W + 1)'({done, cout, sum}), {1'b1, 1'b0, 32'h3});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check("b2b_second", (W + 1)'({done, cout, sum}), {1'b1, 1'b1, 32'h0});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h7, 32'h9, 1'b1);
    idle(NBYTES + 2);

    // Reset mid-operation (idx == 2): no done, outputs cleared
    cycle(1'b0, 1'b1, 32'hAAAA_5555, 32'h1357_9BDF, 1'b1);
    idle(2);
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
    idle(NBYTES + 3);
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, rnd_w(), rnd_w(), 1'($urandom()));
    idle(NBYTES + 2);

    // NBYTES=1 build
    rst = 1'b0; start = 1'b0;
    start1 = 1'b1; a1 = 8'hF0; b1 = 8'h20; cin1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    check("nb1_busy", (W + 1)'({busy1, done1}), (W + 1)'(2'b10));
    @(posedge clk); #1;
    check("nb1_done", (W + 1)'({busy1, done1}), (W + 1)'(2'b01));
    check("nb1_result", (W + 1)'({cout1, sum1}), (W + 1)'(9'h111));
    @(posedge clk); #1;
    check("nb1_idle", (W + 1)'({busy1, done1}), '0);
    check("nb1_hold", (W + 1)'({cout1, sum1}), (W + 1)'(9'h111));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Sequencer that performs an NBYTES-wide addition by time-multiplexing the codebase's 8-bit ripple-carry adder (a, b, cin -> sum, cout). It processes one byte per clock, least-significant byte first, and carries between bytes in a register. A start/busy/done handshake frames each operation. It sits between a host that holds wide operands and the single shared 8-bit adder datapath, and sequences that adder byte by byte.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16; W = 8*NBYTES
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin an operation; sampled only when accepted (see Operation)
- a  in  W  operand A; sampled on the accepting edge only
- b  in  W  operand B; sampled on the accepting edge only
- cin  in  1  carry into byte 0; sampled on the accepting edge only
- busy  out  1  high while bytes are being processed
- done  out  1  single-cycle pulse; sum and cout are valid from this cycle on
- sum  out  W  registered result; held until the next completion
- cout  out  1  registered carry out of the top byte; held with sum

## Operation
- One 8-bit adder instance. Inputs: low byte of A shift register, low byte of B shift register, carry register. No other adder is used.
- FSM states:
  - IDLE: no operation in progress.
  - RUN: one byte processed per cycle.
  - DONE: one cycle; done=1.
- IDLE, start=1: capture a, b into shift registers; carry_r <= cin; idx <= 0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Adder sum byte shifts into the top of the internal result shift register, which shifts right by 8.
  - carry_r <= adder cout.
  - A and B shift registers shift right by 8.
  - idx <= idx+1.
- RUN, when idx == NBYTES-1:
  - sum <= final result, including the current byte.
  - cout <= adder cout.
  - Go to DONE.
- DONE: done=1.
  - start=1: accept new operands exactly as in IDLE, go to RUN (back-to-back).
  - start=0: go to IDLE.
- start while in RUN is ignored. Operands are not resampled and the current operation is unaffected.
- Arithmetic:
  - {cout, sum} = a + b + cin, exact modulo 2^(W+1).
  - The carry chains through every byte boundary.
  - No overflow flag.
- sum and cout change only on the edge entering DONE. They are stable in IDLE, RUN and DONE.
- rst=1 (any state, including mid-RUN):
  - Next state is IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry_r and idx are cleared.
  - An aborted operation never produces done.
- NBYTES=1: RUN lasts one cycle, then DONE.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0; state IDLE.
- Edge E0 accepts start, with state in IDLE or DONE.
- busy is 1 in the cycles following edges E0 .. E0+NBYTES-1, i.e. exactly NBYTES cycles.
- done is 1 for exactly the one cycle following edge E0+NBYTES.
- Latency: done is seen NBYTES+1 cycles after the cycle in which start was asserted.
- Throughput: with start held high continuously, one result every NBYTES+1 cycles.
- busy and done are never both 1.
- The a, b and cin inputs may change freely after the accepting edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- NBYTES=4; a=0x12345678, b=0x11111111, cin=0, start 1 cycle -> busy for 4 cycles, then done 1 cycle; sum=0x23456789, cout=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> carry ripples through all 4 bytes; sum=0x00000000, cout=1. Separately a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1.
- Start 0x00FF00FF+0x00010001 (cin=0). Pulse start two cycles later with different operands while busy -> pulse ignored; result 0x01000100, cout=0; no second done.
- Hold start=1 continuously with new operands presented at each DONE cycle -> results every 5 cycles. Each sum is correct and matches its own operands, e.g. 1+2 -> 3, then 0xFFFFFFFF+1 -> 0 with cout=1.
- Assert rst for 1 cycle at idx=2 mid-operation -> next cycle IDLE, busy=0, sum=0, cout=0; no done pulse. A fresh start afterwards completes normally.
- NBYTES=1 build: a=0xF0, b=0x20, cin=1 -> busy 1 cycle, done next cycle; sum=0x11, cout=1.
